// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed from latched operands and commit after a fixed, per-class latency.
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    input  logic             Cancel,
    output logic [WIDTH-1:0] Out,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned DW      = 2 * WIDTH;
    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Arithmetic datapath, evaluated on the latched operands
    logic [DW-1:0]    a_sx, b_sx, a_zx, b_zx;
    logic [DW-1:0]    prod_s, prod_u, hilo, res_hilo;
    logic             div_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, div_n, div_d, div_d_safe;
    logic [WIDTH-1:0] q_raw, r_raw, quo, rem;

    assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign a_zx   = {{WIDTH{1'b0}}, a_q};
    assign b_zx   = {{WIDTH{1'b0}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign hilo   = {hi_q, lo_q};

    // One unsigned divider shared by DIV and DIVU; DIV works on magnitudes and fixes signs after
    always_comb begin
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed & a_q[WIDTH-1];
        b_neg      = div_signed & b_q[WIDTH-1];
        a_mag      = a_neg ? -a_q : a_q;
        b_mag      = b_neg ? -b_q : b_q;
        div_n      = a_mag;
        div_d      = b_mag;
        div_d_safe = (div_d == '0) ? WIDTH'(1) : div_d;
        q_raw      = div_n / div_d_safe;
        r_raw      = div_n % div_d_safe;
        quo        = (a_neg ^ b_neg) ? -q_raw : q_raw;
        rem        = a_neg ? -r_raw : r_raw;
    end

    always_comb begin
        res_hilo = hilo;
        case (op_q)
            OP_MULT:  res_hilo = prod_s;
            OP_MULTU: res_hilo = prod_u;
            OP_DIV,
            OP_DIVU:  if (b_q != '0) res_hilo = {rem, quo};
            OP_MADD:  res_hilo = hilo + prod_s;
            OP_MSUB:  res_hilo = hilo - prod_s;
            default:  res_hilo = hilo;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; Cancel always wins over Start and over the final commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start && !Cancel) begin
                    case (Op)
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: begin
                            op_d    = Op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = ((Op == OP_DIV) || (Op == OP_DIVU)) ?
                                      CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                            state_d = S_RUN;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (Cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    hi_d    = res_hilo[DW-1:WIDTH];
                    lo_d    = res_hilo[WIDTH-1:0];
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign Busy = (state_q == S_RUN);
    assign Done = done_q;
    assign Out  = Sel ? hi_q : lo_q;

endmodule
